pwm_duty_decoder: RTL and testbench

//  Receive-side counterpart of the PWM generator path: samples one PWM line
//  (for example lpwm or rpwm) and recovers the duty code the store/pwm path encoded.

---
 rtl/pwm_duty_decoder.sv | 161 ++++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder
//   Recovers the duty code carried by one PWM line. Frames are measured
//   rising edge to rising edge on the synchronised line. A frame whose period
//   is within tolerance reports its high-cycle count as the duty code. A line
//   with no rising edge for 2*PERIOD cycles is flagged as stuck.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   pwm_in       PWM line, asynchronous to clk
//   duty         last recovered duty code
//   duty_valid   1-cycle pulse when duty is (re)written
//   period_err   1-cycle pulse when a frame period is out of tolerance
//   stuck        level, no rising edge seen for 2*PERIOD cycles
//   stuck_level  synchronised line level while stuck, 0 otherwise
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | after reset, waiting for the first rise (first frame partial)
// ST_MEASURE | measuring frames, each rise closes and reports one frame
// ST_STUCK   | no rise for 2*PERIOD cycles, duty mirrors the static level

module pwm_duty_decoder #(
  parameter int unsigned DUTY_W      = 3,
  parameter int unsigned PERIOD      = 8,
  parameter int unsigned TOL         = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic              period_err,
  output logic              stuck,
  output logic              stuck_level
);

  localparam int unsigned CNT_W = $clog2(2 * PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * PERIOD);
  localparam logic [CNT_W-1:0] P_MIN    = CNT_W'(PERIOD - TOL);
  localparam logic [CNT_W-1:0] P_MAX    = CNT_W'(PERIOD + TOL);
  localparam logic [CNT_W-1:0] CODE_MAX = CNT_W'(2 ** DUTY_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STUCK   = 2'd2
  } state_t;

  // Synchroniser and edge detect
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_d_q, s_d_d;
  logic                   s, rise, fall;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
    s      = sync_q[SYNC_STAGES-1];
    s_d_d  = s;
    rise   = s & ~s_d_q;
    fall   = ~s & s_d_q;
  end

  // Period and high-time counters; both saturate at 2*PERIOD so that a
  // dead line keeps pcnt parked at the timeout value.
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;

  always_comb begin
    pcnt_d = pcnt_q;
    hcnt_d = hcnt_q;
    if (rise) begin
      pcnt_d = CNT_W'(1);
      hcnt_d = CNT_W'(1);
    end else begin
      if (pcnt_q != CNT_MAX) pcnt_d = pcnt_q + CNT_W'(1);
      if (s && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
      pcnt_q <= '0;
      hcnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      s_d_q  <= s_d_d;
      pcnt_q <= pcnt_d;
      hcnt_q <= hcnt_d;
    end
  end

  // Frame evaluation uses the counts as they stand in the closing rise cycle,
  // before they are cleared.
  logic              in_tol;
  logic [DUTY_W-1:0] code_meas;
  logic              timeout;

  always_comb begin
    in_tol    = (pcnt_q >= P_MIN) && (pcnt_q <= P_MAX);
    code_meas = (hcnt_q > CODE_MAX) ? '1 : hcnt_q[DUTY_W-1:0];
    timeout   = (pcnt_q == CNT_MAX);
  end

  // FSM with registered outputs
  state_t            state_q;
  logic [DUTY_W-1:0] duty_q;
  logic              duty_valid_q;
  logic              period_err_q;
  logic              stuck_q;
  logic              stuck_level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      duty_q        <= '0;
      duty_valid_q  <= 1'b0;
      period_err_q  <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      duty_valid_q <= 1'b0;
      period_err_q <= 1'b0;
      if (rise) begin
        // Only a rise inside MEASURE closes a complete frame.
        if (state_q == ST_MEASURE) begin
          if (in_tol) begin
            duty_q       <= code_meas;
            duty_valid_q <= 1'b1;
          end else begin
            period_err_q <= 1'b1;
          end
        end
        state_q       <= ST_MEASURE;
        stuck_q       <= 1'b0;
        stuck_level_q <= 1'b0;
      end else if (state_q == ST_STUCK) begin
        if (fall) begin
          stuck_level_q <= 1'b0;
          duty_q        <= '0;
          duty_valid_q  <= 1'b1;
        end
      end else if (timeout) begin
        state_q       <= ST_STUCK;
        stuck_q       <= 1'b1;
        stuck_level_q <= s;
        duty_q        <= s ? '1 : '0;
        duty_valid_q  <= 1'b1;
      end
    end
  end

  assign duty        = duty_q;
  assign duty_valid  = duty_valid_q;
  assign period_err  = period_err_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
module tb_pwm_duty_decoder;

  localparam int SYNC   = 2;
  localparam int PERIOD = 8;
  localparam int TOL    = 1;
  localparam int CMAX   = 7;

  logic       clk;
  logic       rst;
  logic       pwm_in;
  logic [2:0] duty;
  logic       duty_valid;
  logic       period_err;
  logic       stuck;
  logic       stuck_level;

  pwm_duty_decoder #(
    .DUTY_W(3), .PERIOD(PERIOD), .TOL(TOL), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .duty(duty), .duty_valid(duty_valid), .period_err(period_err),
    .stuck(stuck), .stuck_level(stuck_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  // Reference model: keeps the whole driven history since reset and derives
  // frame period/high time from it directly.
  bit         in_hist[$];
  int         c;
  int         mode;       // 0 waiting first rise, 1 measuring, 2 stuck
  int         last_ref;   // interval of last rise (or reset)
  logic [2:0] exp_duty;
  logic       exp_valid, exp_err, exp_stuck, exp_level;

  bit wave[$];

  function automatic bit sv(input int k);
    if (k < SYNC) return 1'b0;
    return in_hist[k-SYNC];
  endfunction

  function automatic logic [6:0] obs();
    return {duty, duty_valid, period_err, stuck, stuck_level};
  endfunction

  function automatic logic [6:0] expv();
    return {exp_duty, exp_valid, exp_err, exp_stuck, exp_level};
  endfunction

  task automatic model_reset();
    in_hist.delete();
    c = 0; mode = 0; last_ref = 0;
    exp_duty = 3'd0; exp_valid = 1'b0; exp_err = 1'b0;
    exp_stuck = 1'b0; exp_level = 1'b0;
  endtask

  task automatic model_step();
    bit s, sd;
    int p, h;
    s  = sv(c);
    sd = sv(c - 1);
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (s && !sd) begin
      if (mode == 1) begin
        p = c - last_ref;
        h = 0;
        for (int k = last_ref; k < c; k++) h += int'(sv(k));
        if ((p - PERIOD) <= TOL && (PERIOD - p) <= TOL) begin
          exp_duty  = 3'((h > CMAX) ? CMAX : h);
          exp_valid = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
      end
      mode = 1; last_ref = c;
      exp_stuck = 1'b0; exp_level = 1'b0;
    end else if (mode == 2) begin
      if (!s && sd) begin
        exp_level = 1'b0; exp_duty = 3'd0; exp_valid = 1'b1;
      end
    end else if (c - last_ref == 2 * PERIOD) begin
      mode = 2;
      exp_stuck = 1'b1; exp_level = s;
      exp_duty = s ? 3'd7 : 3'd0; exp_valid = 1'b1;
    end
    c++;
  endtask

  task automatic tick(input bit v);
    pwm_in = v;
    in_hist.push_back(v);
    @(posedge clk); #1;
    model_step();
  endtask

  task automatic seg(input bit lvl, input int n);
    for (int i = 0; i < n; i++) wave.push_back(lvl);
  endtask

  task automatic frame(input int hi, input int lo);
    seg(1'b1, hi);
    seg(1'b0, lo);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0; pwm_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (obs() !== 7'd0) begin
      n_bad++; $display("FAIL reset_async dut=%b want=%b", obs(), 7'd0);
    end
    for (int i = 0; i < 4; i++) begin
      pwm_in = 1'(i & 1);
      @(posedge clk); #1;
      n_vec++;
      if (obs() !== 7'd0) begin
        n_bad++; $display("FAIL reset_hold cyc=%0d dut=%b want=%b", i, obs(), 7'd0);
      end
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    int nv;
    apply_reset();
    wave.delete();
    for (int f = 0; f < 10; f++) frame(3, 5);
    nv = 0;
    foreach (wave[i]) begin
      tick(wave[i]);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL basic c=%0d dut=%b model=%b", c, obs(), expv());
      end
      if (duty_valid) nv++;
    end
    n_vec++;
    if (nv !== 9) begin
      n_bad++; $display("FAIL basic_valid_count got=%0d want=9", nv);
    end
    n_vec++;
    if ({duty, stuck} !== {3'd3, 1'b0}) begin
      n_bad++; $display("FAIL basic_final duty=%0d stuck=%b want duty=3 stuck=0", duty, stuck);
    end
  endtask

  task automatic test_duty_change();
    int got[$];
    int want[4];
    want = '{3, 7, 1, 3};
    wave.delete();
    frame(7, 1); frame(1, 7); frame(3, 5); frame(3, 5);
    foreach (wave[i]) begin
      tick(wave[i]);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL duty_change c=%0d dut=%b model=%b", c, obs(), expv());
      end
      if (duty_valid) got.push_back(int'(duty));
    end
    n_vec++;
    if (got.size() !== 4) begin
      n_bad++; $display("FAIL duty_change_count got=%0d want=4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (got[i] !== want[i]) begin
          n_bad++; $display("FAIL duty_change_seq idx=%0d got=%0d want=%0d", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_stuck_low();
    int nv, first;
    apply_reset();
    nv = 0; first = -1;
    for (int i = 0; i < 24; i++) begin
      tick(1'b0);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL stuck_low c=%0d dut=%b model=%b", c, obs(), expv());
      end
      if (duty_valid) nv++;
      if (stuck && first < 0) first = i;
    end
    n_vec++;
    if (first !== 2 * PERIOD) begin
      n_bad++; $display("FAIL stuck_low_time got=%0d want=%0d", first, 2 * PERIOD);
    end
    n_vec++;
    if (nv !== 1) begin
      n_bad++; $display("FAIL stuck_low_valids got=%0d want=1", nv);
    end
    n_vec++;
    if ({duty, stuck, stuck_level} !== {3'd0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL stuck_low_final duty=%0d stuck=%b lvl=%b want 0/1/0", duty, stuck, stuck_level);
    end
  endtask

  task automatic test_period_err();
    int nv, ne;
    logic [2:0] duty_at_err;
    apply_reset();
    wave.delete();
    frame(3, 5); frame(3, 5); frame(4, 7); frame(4, 5); frame(3, 5);
    nv = 0; ne = 0; duty_at_err = 3'bx;
    foreach (wave[i]) begin
      tick(wave[i]);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL period_err c=%0d dut=%b model=%b", c, obs(), expv());
      end
      if (duty_valid) nv++;
      if (period_err) begin ne++; duty_at_err = duty; end
    end
    n_vec++;
    if ({nv, ne} !== {32'd3, 32'd1}) begin
      n_bad++; $display("FAIL period_err_counts valid=%0d err=%0d want 3/1", nv, ne);
    end
    n_vec++;
    if (duty_at_err !== 3'd3) begin
      n_bad++; $display("FAIL period_err_hold duty=%0d want=3", duty_at_err);
    end
    n_vec++;
    if (duty !== 3'd4) begin
      n_bad++; $display("FAIL period_9_duty got=%0d want=4", duty);
    end
  endtask

  task automatic test_stuck_high();
    int nv;
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      tick(1'b1);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL stuck_high c=%0d dut=%b model=%b", c, obs(), expv());
      end
    end
    n_vec++;
    if ({duty, stuck, stuck_level} !== {3'd7, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL stuck_high_state duty=%0d stuck=%b lvl=%b want 7/1/1", duty, stuck, stuck_level);
    end
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL stuck_drop c=%0d dut=%b model=%b", c, obs(), expv());
      end
      if (duty_valid) nv++;
    end
    n_vec++;
    if ({nv, 29'd0, duty, stuck, stuck_level} !== {32'd1, 29'd0, 3'd0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL stuck_drop_state valids=%0d duty=%0d stuck=%b lvl=%b want 1/0/1/0", nv, duty, stuck, stuck_level);
    end
    wave.delete();
    frame(3, 5);
    nv = 0;
    foreach (wave[i]) begin
      tick(wave[i]);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL stuck_exit c=%0d dut=%b model=%b", c, obs(), expv());
      end
      if (duty_valid || period_err) nv++;
    end
    n_vec++;
    if ({nv, 31'd0, stuck} !== {32'd0, 31'd0, 1'b0}) begin
      n_bad++; $display("FAIL stuck_exit_state reports=%0d stuck=%b want 0/0", nv, stuck);
    end
    wave.delete();
    frame(3, 5);
    nv = 0;
    foreach (wave[i]) begin
      tick(wave[i]);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL stuck_resume c=%0d dut=%b model=%b", c, obs(), expv());
      end
      if (duty_valid) nv++;
    end
    n_vec++;
    if ({nv, 29'd0, duty} !== {32'd1, 29'd0, 3'd3}) begin
      n_bad++; $display("FAIL stuck_resume_report valids=%0d duty=%0d want 1/3", nv, duty);
    end
  endtask

  task automatic test_reset_midframe();
    int first;
    logic [2:0] first_duty;
    apply_reset();
    wave.delete();
    frame(3, 5); frame(3, 5); frame(3, 1);
    foreach (wave[i]) begin
      tick(wave[i]);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL midframe_pre c=%0d dut=%b model=%b", c, obs(), expv());
      end
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (obs() !== 7'd0) begin
      n_bad++; $display("FAIL midframe_async dut=%b want=%b", obs(), 7'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    wave.delete();
    seg(1'b0, 4); frame(3, 5); frame(3, 5); frame(3, 5);
    first = -1; first_duty = 3'd0;
    foreach (wave[i]) begin
      tick(wave[i]);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL midframe_post c=%0d dut=%b model=%b", c, obs(), expv());
      end
      if (duty_valid && first < 0) begin first = i; first_duty = duty; end
    end
    // pwm_in rises at intervals 4 and 12; the second one closes the first frame.
    n_vec++;
    if (first !== 12 + SYNC) begin
      n_bad++; $display("FAIL midframe_first_valid got=%0d want=%0d", first, 12 + SYNC);
    end
    n_vec++;
    if (first_duty !== 3'd3) begin
      n_bad++; $display("FAIL midframe_first_duty got=%0d want=3", first_duty);
    end
  endtask

  task automatic test_random();
    int per, hi;
    apply_reset();
    wave.delete();
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(7, 0) == 0) begin
        seg(1'($urandom_range(1, 0)), int'($urandom_range(24, 18)));
      end else begin
        per = int'($urandom_range(11, 6));
        hi  = int'($urandom_range(per - 1, 1));
        frame(hi, per - hi);
      end
    end
    foreach (wave[i]) begin
      tick(wave[i]);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL random c=%0d dut=%b model=%b", c, obs(), expv());
      end
      if (duty_valid && period_err) begin
        n_bad++; $display("FAIL random_exclusive c=%0d valid=%b err=%b want not both", c, duty_valid, period_err);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b0;
    pwm_in = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_duty_change();
    test_stuck_low();
    test_period_err();
    test_stuck_high();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
